// File: rtl/acc_cpu_param.sv
// Parametrised accumulator core: ALU, accumulator, carry/zero flags and a
// 2**ADDR_W-word data memory, sequenced by a start/busy/done FSM.
//
// state    | meaning
// ---------+------------------------------------------------------
// S_IDLE   | waiting for start_i; instruction fields captured here
// S_DECODE | fields latched, busy asserted
// S_EXEC   | ALU result, flags and memory write committed at end
// S_DONE   | done_o pulse, result visible
module acc_cpu_param #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [3:0]        opcode_i,
  input  logic [DATA_W-1:0] operand_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [DATA_W-1:0] acc_out_o,
  output logic              flag_c_o,
  output logic              flag_z_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {S_IDLE, S_DECODE, S_EXEC, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [3:0]        op_q;
  logic [DATA_W-1:0] opnd_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic              c_q, c_d;
  logic              z_q, z_d;
  logic              err_q, err_d;
  logic              mem_we;
  logic              wr_acc;
  logic [DATA_W-1:0] mem_rd;
  logic [DATA_W-1:0] mem_q [DEPTH];

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start_i) state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC:   state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    acc_d  = acc_q;
    c_d    = c_q;
    z_d    = z_q;
    err_d  = err_q;
    mem_we = 1'b0;
    wr_acc = 1'b0;
    mem_rd = mem_q[addr_q];
    if (state_q == S_EXEC) begin
      // Carry and borrow both fall out of the extra top bit of a DATA_W+1 op.
      case (op_q)
        4'h0: begin {c_d, acc_d} = {1'b0, acc_q} + {1'b0, opnd_q}; wr_acc = 1'b1; end
        4'h1: begin {c_d, acc_d} = {1'b0, acc_q} - {1'b0, opnd_q}; wr_acc = 1'b1; end
        4'h2: mem_we = 1'b1;
        4'h3: begin acc_d = mem_rd;           wr_acc = 1'b1; end
        4'h4: begin acc_d = opnd_q;           wr_acc = 1'b1; end
        4'h5: begin acc_d = acc_q & opnd_q;   wr_acc = 1'b1; end
        4'h6: begin acc_d = acc_q | opnd_q;   wr_acc = 1'b1; end
        4'h7: begin acc_d = acc_q ^ opnd_q;   wr_acc = 1'b1; end
        4'h8: begin acc_d = ~acc_q;           wr_acc = 1'b1; end
        4'h9: begin
          acc_d  = {acc_q[DATA_W-2:0], 1'b0};
          c_d    = acc_q[DATA_W-1];
          wr_acc = 1'b1;
        end
        4'hA: begin
          acc_d  = {1'b0, acc_q[DATA_W-1:1]};
          c_d    = acc_q[0];
          wr_acc = 1'b1;
        end
        4'hB: begin {c_d, acc_d} = {1'b0, acc_q} + {1'b0, mem_rd}; wr_acc = 1'b1; end
        4'hC: begin {c_d, acc_d} = {1'b0, acc_q} - {1'b0, mem_rd}; wr_acc = 1'b1; end
        4'hD: ;
        default: err_d = 1'b1;
      endcase
      if (wr_acc) z_d = (acc_d == '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      opnd_q  <= '0;
      addr_q  <= '0;
      acc_q   <= '0;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && start_i) begin
        op_q   <= opcode_i;
        opnd_q <= operand_i;
        addr_q <= addr_i;
      end
      acc_q <= acc_d;
      c_q   <= c_d;
      z_q   <= z_d;
      err_q <= err_d;
      if (mem_we) mem_q[addr_q] <= acc_q;
    end
  end

  assign busy_o    = (state_q != S_IDLE);
  assign done_o    = (state_q == S_DONE);
  assign err_o     = err_q;
  assign acc_out_o = acc_q;
  assign flag_c_o  = c_q;
  assign flag_z_o  = z_q;

endmodule
